// File: rtl/fault_halt_sequencer.sv
// fault_halt_sequencer
//   Turns the distance-threshold flag d_val into drive control for the line
//   follower. On each sample tick it looks for a high-low-high fault pattern.
//   A confirmed pattern halts the motors for a timed hold and then re-arms.
//   Confirmed faults are counted.
//
//   Optional feature macro: FAULT_STICKY_EN
//     defined   : HALT is held until fault_ack=1; the hold timer does not release it.
//     undefined : fault_ack is ignored; HALT releases after HALT_TICKS ticks.
//
// Ports
//   clk          in   1      system clock
//   rst          in   1      asynchronous reset, active low
//   enable       in   1      1 = running, 0 = forced to IDLE (count kept)
//   d_val        in   1      asynchronous distance-above-threshold flag
//   fault_ack    in   1      operator acknowledge (sticky build only)
//   clear_count  in   1      synchronous clear of fault_count (beats increment)
//   halt         out  1      1 = motors must stop (high exactly in HALT)
//   fault_pulse  out  1      one-clk pulse per confirmed fault
//   fault_count  out  CNT_W  saturating count of confirmed faults
//   state_dbg    out  3      current FSM state encoding
//   ground       out  1      constant 0
module fault_halt_sequencer #(
    parameter int unsigned CLK_DIV    = 50000,
    parameter int unsigned MIN_PULSE  = 2,
    parameter int unsigned MAX_GAP    = 50,
    parameter int unsigned HALT_TICKS = 500,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             d_val,
    input  logic             fault_ack,
    input  logic             clear_count,
    output logic             halt,
    output logic             fault_pulse,
    output logic [CNT_W-1:0] fault_count,
    output logic [2:0]       state_dbg,
    output logic             ground
);

    localparam int unsigned PRE_W  = ($clog2(CLK_DIV) > 0) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned WID_W  = $clog2(MIN_PULSE + 1);
    localparam int unsigned GAP_W  = $clog2(MAX_GAP + 1);
    localparam int unsigned HTMR_W = $clog2(HALT_TICKS + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_DIV - 1);
    localparam logic [WID_W-1:0]  WID_MIN   = WID_W'(MIN_PULSE);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(MAX_GAP);
    localparam logic [HTMR_W-1:0] HTMR_LOAD = HTMR_W'(HALT_TICKS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FIRST_HI  = 3'd1,
        S_GAP_LO    = 3'd2,
        S_SECOND_HI = 3'd3,
        S_HALT      = 3'd4,
        S_REARM     = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              d_meta, d_s;
    logic [PRE_W-1:0]  presc_q;
    logic              tick;
    logic [WID_W-1:0]  wid_q, wid_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [HTMR_W-1:0] htmr_q, htmr_d;
    logic [CNT_W-1:0]  count_d;
    logic              pulse_d;
    logic              confirm;

    assign ground    = 1'b0;
    assign state_dbg = state_q;

`ifndef FAULT_STICKY_EN
    logic ack_unused;
    assign ack_unused = fault_ack;
`endif

    // Sample strobe; the prescaler only runs while enabled.
    assign tick = enable && (presc_q == PRE_LAST);

    // Synchroniser and prescaler.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_meta  <= 1'b0;
            d_s     <= 1'b0;
            presc_q <= '0;
        end else begin
            d_meta  <= d_val;
            d_s     <= d_meta;
            presc_q <= (!enable || tick) ? '0 : presc_q + 1'b1;
        end
    end

    // State register, timers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wid_q       <= '0;
            gap_q       <= '0;
            htmr_q      <= '0;
            halt        <= 1'b0;
            fault_pulse <= 1'b0;
            fault_count <= '0;
        end else begin
            state_q     <= state_d;
            wid_q       <= wid_d;
            gap_q       <= gap_d;
            htmr_q      <= htmr_d;
            halt        <= (state_d == S_HALT);
            fault_pulse <= pulse_d;
            fault_count <= count_d;
        end
    end

    // Next-state, timer and counter logic.
    always_comb begin
        state_d = state_q;
        wid_d   = wid_q;
        gap_d   = gap_q;
        htmr_d  = htmr_q;
        pulse_d = 1'b0;
        confirm = 1'b0;
        count_d = fault_count;

        if (!enable) begin
            state_d = S_IDLE;
            wid_d   = '0;
            gap_d   = '0;
            htmr_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tick && d_s) begin
                        state_d = S_FIRST_HI;
                        wid_d   = WID_W'(1);
                    end
                end
                S_FIRST_HI: begin
                    if (tick) begin
                        if (d_s) begin
                            if (wid_q < WID_MIN) wid_d = wid_q + 1'b1;
                        end else if (wid_q >= WID_MIN) begin
                            state_d = S_GAP_LO;
                            gap_d   = GAP_W'(1);
                        end else begin
                            state_d = S_IDLE;
                            wid_d   = '0;
                        end
                    end
                end
                S_GAP_LO: begin
                    if (tick) begin
                        if (d_s) begin
                            // A single-tick minimum confirms on the first high sample.
                            if (WID_MIN == WID_W'(1)) begin
                                confirm = 1'b1;
                            end else begin
                                state_d = S_SECOND_HI;
                                wid_d   = WID_W'(1);
                            end
                        end else if (gap_q == GAP_MAX) begin
                            state_d = S_IDLE;
                            gap_d   = '0;
                            wid_d   = '0;
                        end else begin
                            gap_d = gap_q + 1'b1;
                        end
                    end
                end
                S_SECOND_HI: begin
                    if (tick) begin
                        if (!d_s) begin
                            state_d = S_IDLE;
                            wid_d   = '0;
                            gap_d   = '0;
                        end else if ((wid_q + 1'b1) >= WID_MIN) begin
                            confirm = 1'b1;
                        end else begin
                            wid_d = wid_q + 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    if (tick && (htmr_q != '0)) htmr_d = htmr_q - 1'b1;
`ifdef FAULT_STICKY_EN
                    if (fault_ack) begin
                        state_d = S_REARM;
                        htmr_d  = '0;
                    end
`else
                    // Release on the tick that takes the timer to zero.
                    if (tick && (htmr_q <= HTMR_W'(1))) begin
                        state_d = S_REARM;
                        htmr_d  = '0;
                    end
`endif
                end
                S_REARM: begin
                    // Wait for d_val to drop so a held obstacle cannot retrigger.
                    if (tick && !d_s) state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    wid_d   = '0;
                    gap_d   = '0;
                    htmr_d  = '0;
                end
            endcase
        end

        if (confirm) begin
            state_d = S_HALT;
            htmr_d  = HTMR_LOAD;
            wid_d   = '0;
            gap_d   = '0;
            pulse_d = 1'b1;
        end

        // Clear has priority over a same-cycle increment.
        if (clear_count) begin
            count_d = '0;
        end else if (confirm && (fault_count != {CNT_W{1'b1}})) begin
            count_d = fault_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fault_halt_sequencer.sv
// Directed bench for fault_halt_sequencer (CLK_DIV=4 MIN_PULSE=2 MAX_GAP=5
// HALT_TICKS=3 CNT_W=4). Each d_val level is held a whole number of tick periods,
// so every level is seen by exactly one tick per period regardless of phase.
module tb_fault_halt_sequencer;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             d_val;
    logic             fault_ack;
    logic             clear_count;
    logic             halt;
    logic             fault_pulse;
    logic [CNT_W-1:0] fault_count;
    logic [2:0]       state_dbg;
    logic             ground;

    int checks    = 0;
    int failures  = 0;
    int pulse_cnt = 0;
    int halt_cnt  = 0;
    int exp_count = 0;

    fault_halt_sequencer #(
        .CLK_DIV    (CLK_DIV),
        .MIN_PULSE  (2),
        .MAX_GAP    (5),
        .HALT_TICKS (3),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .d_val       (d_val),
        .fault_ack   (fault_ack),
        .clear_count (clear_count),
        .halt        (halt),
        .fault_pulse (fault_pulse),
        .fault_count (fault_count),
        .state_dbg   (state_dbg),
        .ground      (ground)
    );

    always #5 clk = ~clk;

    // Count clocks with fault_pulse / halt high, sampled away from the active edge.
    always @(negedge clk) begin
        if (fault_pulse === 1'b1) pulse_cnt = pulse_cnt + 1;
        if (halt === 1'b1) halt_cnt = halt_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog sim time exhausted");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    task automatic hold(input logic v, input int nticks);
        d_val = v;
        repeat (nticks * CLK_DIV) @(negedge clk);
    endtask

    task automatic run_pattern();
        hold(1'b1, 3);
        hold(1'b0, 2);
        hold(1'b1, 3);
    endtask

    task automatic clr_mon();
        pulse_cnt = 0;
        halt_cnt  = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b1; d_val = 1'b0; fault_ack = 1'b0; clear_count = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (halt !== 1'b0) begin failures++; $display("FAIL reset_halt got=%0b exp=0", halt); end
        checks++; if (fault_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%0b exp=0", fault_pulse); end
        checks++; if (fault_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fault_count); end
        checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        checks++; if (ground !== 1'b0) begin failures++; $display("FAIL ground got=%0b exp=0", ground); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL post_reset_state got=%0d exp=0", state_dbg); end
    endtask

    task automatic test_glitch();
        clr_mon();
        hold(1'b1, 1);
        hold(1'b0, 4);
        checks++; if (pulse_cnt !== 0) begin failures++; $display("FAIL glitch_pulse got=%0d exp=0", pulse_cnt); end
        checks++; if (halt_cnt !== 0) begin failures++; $display("FAIL glitch_halt got=%0d exp=0", halt_cnt); end
        checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL glitch_state got=%0d exp=0", state_dbg); end
        checks++; if (fault_count !== 4'd0) begin failures++; $display("FAIL glitch_count got=%0d exp=0", fault_count); end
    endtask

    task automatic test_gap_timeout();
        clr_mon();
        hold(1'b1, 3);
        hold(1'b0, 6);
        hold(1'b1, 3);
        hold(1'b0, 8);
        checks++; if (pulse_cnt !== 0) begin failures++; $display("FAIL gap_pulse got=%0d exp=0", pulse_cnt); end
        checks++; if (halt_cnt !== 0) begin failures++; $display("FAIL gap_halt got=%0d exp=0", halt_cnt); end
        checks++; if (fault_count !== 4'd0) begin failures++; $display("FAIL gap_count got=%0d exp=0", fault_count); end
        checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL gap_state got=%0d exp=0", state_dbg); end
    endtask

    task automatic test_pattern();
        clr_mon();
        fault_ack = 1'b1;
        run_pattern();
        hold(1'b0, 6);
        fault_ack = 1'b0;
        exp_count = exp_count + 1;
        checks++; if (pulse_cnt !== 1) begin failures++; $display("FAIL pattern_pulse got=%0d exp=1", pulse_cnt); end
        checks++; if (halt_cnt !== 12) begin failures++; $display("FAIL pattern_halt_clks got=%0d exp=12", halt_cnt); end
        checks++; if (fault_count !== CNT_W'(exp_count)) begin failures++; $display("FAIL pattern_count got=%0d exp=%0d", fault_count, exp_count); end
        checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL pattern_state got=%0d exp=0", state_dbg); end
        checks++; if (halt !== 1'b0) begin failures++; $display("FAIL pattern_halt_end got=%0b exp=0", halt); end
    endtask

    task automatic test_rearm();
        clr_mon();
        hold(1'b1, 3);
        hold(1'b0, 2);
        hold(1'b1, 8);
        exp_count = exp_count + 1;
        checks++; if (state_dbg !== 3'd5) begin failures++; $display("FAIL rearm_state got=%0d exp=5", state_dbg); end
        checks++; if (halt !== 1'b0) begin failures++; $display("FAIL rearm_halt got=%0b exp=0", halt); end
        checks++; if (pulse_cnt !== 1) begin failures++; $display("FAIL rearm_pulse got=%0d exp=1", pulse_cnt); end
        checks++; if (halt_cnt !== 12) begin failures++; $display("FAIL rearm_halt_clks got=%0d exp=12", halt_cnt); end
        hold(1'b0, 2);
        checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL rearm_exit_state got=%0d exp=0", state_dbg); end
        checks++; if (fault_count !== CNT_W'(exp_count)) begin failures++; $display("FAIL rearm_count got=%0d exp=%0d", fault_count, exp_count); end
    endtask

    task automatic test_enable_mid_halt();
        run_pattern();
        exp_count = exp_count + 1;
        checks++; if (halt !== 1'b1) begin failures++; $display("FAIL en_pre_halt got=%0b exp=1", halt); end
        checks++; if (state_dbg !== 3'd4) begin failures++; $display("FAIL en_pre_state got=%0d exp=4", state_dbg); end
        enable = 1'b0;
        d_val  = 1'b0;
        @(posedge clk); #1;
        checks++; if (halt !== 1'b0) begin failures++; $display("FAIL en_off_halt got=%0b exp=0", halt); end
        checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL en_off_state got=%0d exp=0", state_dbg); end
        checks++; if (fault_count !== CNT_W'(exp_count)) begin failures++; $display("FAIL en_off_count got=%0d exp=%0d", fault_count, exp_count); end
        @(negedge clk);
        enable = 1'b1;
        hold(1'b0, 2);
    endtask

    task automatic test_clear();
        logic seen;
        // Clear held across the confirming cycle: the increment must lose.
        clr_mon();
        clear_count = 1'b1;
        run_pattern();
        hold(1'b0, 4);
        clear_count = 1'b0;
        exp_count = 0;
        checks++; if (pulse_cnt !== 1) begin failures++; $display("FAIL clr_hold_pulse got=%0d exp=1", pulse_cnt); end
        checks++; if (fault_count !== 4'd0) begin failures++; $display("FAIL clr_hold_count got=%0d exp=0", fault_count); end
        // Clear asserted in the fault_pulse cycle.
        hold(1'b1, 3);
        hold(1'b0, 2);
        d_val = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (fault_pulse === 1'b1) begin
                seen = 1'b1;
                checks++; if (fault_count !== 4'd1) begin failures++; $display("FAIL clr_pulse_count got=%0d exp=1", fault_count); end
                clear_count = 1'b1;
                @(negedge clk);
                clear_count = 1'b0;
            end
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL clr_pulse_seen got=%0b exp=1", seen); end
        checks++; if (fault_count !== 4'd0) begin failures++; $display("FAIL clr_pulse_after got=%0d exp=0", fault_count); end
        hold(1'b0, 6);
    endtask

    task automatic test_saturate();
        for (int n = 0; n < 15; n++) begin
            run_pattern();
            hold(1'b0, 4);
        end
        checks++; if (fault_count !== 4'd15) begin failures++; $display("FAIL sat_fill got=%0d exp=15", fault_count); end
        clr_mon();
        run_pattern();
        hold(1'b0, 4);
        checks++; if (pulse_cnt !== 1) begin failures++; $display("FAIL sat_pulse got=%0d exp=1", pulse_cnt); end
        checks++; if (fault_count !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", fault_count); end
    endtask

`ifdef FAULT_STICKY_EN
    task automatic test_sticky();
        clr_mon();
        run_pattern();
        hold(1'b0, 10);
        exp_count = exp_count + 1;
        checks++; if (halt !== 1'b1) begin failures++; $display("FAIL sticky_held got=%0b exp=1", halt); end
        checks++; if (state_dbg !== 3'd4) begin failures++; $display("FAIL sticky_state got=%0d exp=4", state_dbg); end
        checks++; if (pulse_cnt !== 1) begin failures++; $display("FAIL sticky_pulse got=%0d exp=1", pulse_cnt); end
        fault_ack = 1'b1;
        @(posedge clk); #1;
        checks++; if (halt !== 1'b0) begin failures++; $display("FAIL sticky_ack_halt got=%0b exp=0", halt); end
        checks++; if (state_dbg !== 3'd5) begin failures++; $display("FAIL sticky_ack_state got=%0d exp=5", state_dbg); end
        @(negedge clk);
        fault_ack = 1'b0;
        hold(1'b0, 2);
        checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL sticky_idle got=%0d exp=0", state_dbg); end
        checks++; if (fault_count !== CNT_W'(exp_count)) begin failures++; $display("FAIL sticky_count got=%0d exp=%0d", fault_count, exp_count); end
    endtask
`endif

    task automatic test_reset_mid_halt();
        run_pattern();
        checks++; if (halt !== 1'b1) begin failures++; $display("FAIL rst_pre_halt got=%0b exp=1", halt); end
        rst = 1'b0;
        #1;
        checks++; if (halt !== 1'b0) begin failures++; $display("FAIL rst_mid_halt got=%0b exp=0", halt); end
        checks++; if (fault_pulse !== 1'b0) begin failures++; $display("FAIL rst_mid_pulse got=%0b exp=0", fault_pulse); end
        checks++; if (fault_count !== 4'd0) begin failures++; $display("FAIL rst_mid_count got=%0d exp=0", fault_count); end
        checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL rst_mid_state got=%0d exp=0", state_dbg); end
        d_val = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        hold(1'b0, 2);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_gap_timeout();
`ifdef FAULT_STICKY_EN
        test_enable_mid_halt();
        test_sticky();
`else
        test_pattern();
        test_rearm();
        test_enable_mid_halt();
        test_clear();
        test_saturate();
`endif
        test_reset_mid_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
